fetch_prefetch_unit: RTL

FETCH_PREFETCH_UNIT -- requirements
Module: fetch_prefetch_unit

---
 rtl/fetch_pkg.sv | 16 +
 rtl/fetch_fifo.sv | 71 +++++++
 rtl/fetch_prefetch_unit.sv | 122 ++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and default parameters for the instruction prefetch unit.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } fetch_state_e;

  localparam int DEF_ADDR_W   = 16;
  localparam int DEF_INSTR_W  = 16;
  localparam int DEF_DEPTH    = 4;
  localparam int DEF_PC_STEP  = 2;
  localparam int DEF_RESET_PC = 0;

endpackage

// File: rtl/fetch_fifo.sv
// Circular prefetch queue with wrapping pointers and a single-cycle flush.
// Flush wins over any push or pop in the same cycle.
module fetch_fifo #(
  parameter  int DW    = 33,
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          pop_i,
  output logic [DW-1:0] rdata_o,
  output logic          valid_o,
  output logic [CW-1:0] count_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign do_pop  = pop_i & (count_q != '0);
  assign do_push = push_i & ((count_q != CW'(DEPTH)) | do_pop);

  assign valid_o = (count_q != '0);
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Pointer and occupancy next-state; flush empties the queue outright.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer/occupancy registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Instruction prefetcher: one outstanding memory read, results queued in
// fetch order with their PC and error flag.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | no request outstanding; may issue when queue has room
//   ST_WAIT | request accepted, response will be queued
//   ST_DROP | request accepted before a redirect, response is discarded
module fetch_prefetch_unit
  import fetch_pkg::*;
#(
  parameter  int ADDR_W   = DEF_ADDR_W,
  parameter  int INSTR_W  = DEF_INSTR_W,
  parameter  int DEPTH    = DEF_DEPTH,
  parameter  int PC_STEP  = DEF_PC_STEP,
  parameter  int RESET_PC = DEF_RESET_PC,
  localparam int CNT_W    = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               halt,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_stall,
  input  logic               imem_done,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_err,
  output logic               out_valid,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  output logic [ADDR_W-1:0]  out_pc_next,
  output logic               out_err,
  input  logic               out_ready,
  output logic [CNT_W-1:0]   count
);

  localparam int ENT_W = 1 + ADDR_W + INSTR_W;

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] req_pc_q, req_pc_d;
  logic              accept, push, pop, has_room;
  logic              fifo_valid;
  logic [ENT_W-1:0]  head;

  // A same-cycle pop frees a slot, so a full queue can still issue.
  assign pop      = fifo_valid & out_ready;
  assign has_room = (count < CNT_W'(DEPTH)) | pop;
  // rst gating keeps the request low for the whole reset interval.
  assign imem_req = rst & (state_q == ST_IDLE) & ~halt & ~redirect_valid & has_room;
  assign accept   = imem_req & ~imem_stall;
  assign imem_addr = pc_q;

  // Request/response sequencing and push decision.
  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    unique case (state_q)
      ST_IDLE: if (accept) state_d = ST_WAIT;
      ST_WAIT: begin
        if (imem_done) begin
          // A response coinciding with a redirect belongs to the old path.
          state_d = ST_IDLE;
          push    = ~redirect_valid;
        end else if (redirect_valid) begin
          state_d = ST_DROP;
        end
      end
      ST_DROP: if (imem_done) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Fetch PC and the PC of the in-flight request.
  always_comb begin
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    if (redirect_valid) begin
      pc_d = redirect_pc;
    end else if (accept) begin
      pc_d     = pc_q + ADDR_W'(PC_STEP);
      req_pc_d = pc_q;
    end
  end

  // State, fetch PC and request PC registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      pc_q     <= ADDR_W'(RESET_PC);
      req_pc_q <= ADDR_W'(RESET_PC);
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
    end
  end

  fetch_fifo #(
    .DW    (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (redirect_valid),
    .push_i  (push),
    .wdata_i ({imem_err, req_pc_q, imem_rdata}),
    .pop_i   (pop),
    .rdata_o (head),
    .valid_o (fifo_valid),
    .count_o (count)
  );

  assign out_valid   = fifo_valid;
  assign out_err     = fifo_valid & head[ENT_W-1];
  assign out_pc      = head[INSTR_W +: ADDR_W];
  assign out_instr   = head[INSTR_W-1:0];
  assign out_pc_next = out_pc + ADDR_W'(PC_STEP);

endmodule
